// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 16-bit pipeline.
// Owns the PC, drives the instruction-memory address and loads the IF/ID
// register. Two-word LDM instructions are assembled into instruction plus
// immediate before being handed to decode.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   stall              hold PC, FSM and IF/ID
//   redirect           taken jump/branch: load redirect_pc, flush IF/ID
//   redirect_pc        redirect target
//   pc_enable          0 = halt: PC/FSM frozen, bubbles issued
//   imem_addr          instruction memory address (= pc, combinational)
//   imem_data          word at imem_addr, same cycle
//   ifid_inst/imm/pc   IF/ID payload to decode
//   ifid_valid         IF/ID holds a real instruction
//
// Optional: `define FETCH_BOOT_VECTOR_EN adds a one-cycle BOOT state that
// reads the start PC from imem[0]; RESET_VECTOR is then unused.
module fetch_stage #(
  parameter int unsigned         PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [15:0]         NOP_WORD     = 16'h4000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                pc_enable,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_data,
  output logic [15:0]         ifid_inst,
  output logic [15:0]         ifid_imm,
  output logic [PC_WIDTH-1:0] ifid_pc,
  output logic                ifid_valid
);

  localparam int unsigned IW     = 16;
  localparam logic [4:0]  OP_LDM = 5'b10001;

  localparam logic [1:0] ST_FETCH     = 2'd0;
  localparam logic [1:0] ST_FETCH_IMM = 2'd1;
`ifdef FETCH_BOOT_VECTOR_EN
  localparam logic [1:0] ST_BOOT      = 2'd2;
`endif

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [IW-1:0]       hold_inst_q, hold_inst_d;
  logic [PC_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic [IW-1:0]       ifid_inst_q, ifid_inst_d;
  logic [IW-1:0]       ifid_imm_q, ifid_imm_d;
  logic [PC_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic                ifid_valid_q, ifid_valid_d;
  logic                bubble;
  logic [PC_WIDTH-1:0] pc_inc;

  // Wraps modulo 2^PC_WIDTH.
  assign pc_inc = pc_q + PC_WIDTH'(1);

  // Next-state: redirect > stall > halt > normal fetch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_inst_d  = hold_inst_q;
    hold_pc_d    = hold_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_imm_d   = ifid_imm_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    bubble       = 1'b0;

    if (redirect) begin
      // Any half-assembled LDM is simply abandoned.
      pc_d    = redirect_pc;
      state_d = ST_FETCH;
      bubble  = 1'b1;
    end else if (stall) begin
      // Everything holds.
    end else if (!pc_enable) begin
      // State kept so an LDM split across the halt still completes.
      bubble = 1'b1;
    end else begin
      case (state_q)
`ifdef FETCH_BOOT_VECTOR_EN
        ST_BOOT: begin
          pc_d    = PC_WIDTH'(imem_data);
          state_d = ST_FETCH;
          bubble  = 1'b1;
        end
`endif
        ST_FETCH_IMM: begin
          // Second word is immediate data, never decoded.
          ifid_inst_d  = hold_inst_q;
          ifid_imm_d   = imem_data;
          ifid_pc_d    = hold_pc_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_inc;
          state_d      = ST_FETCH;
        end
        default: begin
          pc_d = pc_inc;
          if (imem_data[15:11] == OP_LDM) begin
            hold_inst_d = imem_data;
            hold_pc_d   = pc_q;
            state_d     = ST_FETCH_IMM;
            bubble      = 1'b1;
          end else begin
            ifid_inst_d  = imem_data;
            ifid_imm_d   = '0;
            ifid_pc_d    = pc_q;
            ifid_valid_d = 1'b1;
          end
        end
      endcase
    end

    // Bubble leaves ifid_pc untouched.
    if (bubble) begin
      ifid_inst_d  = NOP_WORD;
      ifid_imm_d   = '0;
      ifid_valid_d = 1'b0;
    end
  end

  // State and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef FETCH_BOOT_VECTOR_EN
      state_q <= ST_BOOT;
      pc_q    <= '0;
`else
      state_q <= ST_FETCH;
      pc_q    <= RESET_VECTOR;
`endif
      hold_inst_q  <= '0;
      hold_pc_q    <= '0;
      ifid_inst_q  <= NOP_WORD;
      ifid_imm_q   <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_inst_q  <= hold_inst_d;
      hold_pc_q    <= hold_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_imm_q   <= ifid_imm_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_addr  = pc_q;
  assign ifid_inst  = ifid_inst_q;
  assign ifid_imm   = ifid_imm_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. A behavioural model
// predicts the IF/ID contents and fetch address after every clock edge and
// queues them; a monitor compares the DUT after each edge.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h4000;
  localparam logic [15:0] RV  = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        pc_enable = 1'b1;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ifid_inst, ifid_imm, ifid_pc;
  logic        ifid_valid;

  logic [15:0] mem [0:65535];
  assign imem_data = mem[imem_addr];

  fetch_stage #(.PC_WIDTH(16), .RESET_VECTOR(RV), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc_enable(pc_enable),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .ifid_inst(ifid_inst), .ifid_imm(ifid_imm), .ifid_pc(ifid_pc),
    .ifid_valid(ifid_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        valid;
    logic [15:0] addr;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: address of the next word to read, an optional LDM
  // waiting for its immediate, and what decode currently sees.
  logic [15:0] m_pc;
  bit          m_boot;
  bit          ldm_waiting;
  logic [15:0] ldm_word, ldm_addr;
  obs_t        m_out;

  function automatic obs_t sample();
    obs_t o;
    o.inst = ifid_inst; o.imm = ifid_imm; o.pc = ifid_pc;
    o.valid = ifid_valid; o.addr = imem_addr;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t: got inst=%h imm=%h pc=%h v=%b addr=%h, want inst=%h imm=%h pc=%h v=%b addr=%h",
               name, $time, got.inst, got.imm, got.pc, got.valid, got.addr,
               want.inst, want.imm, want.pc, want.valid, want.addr);
    end
  endtask

  task automatic model_reset();
`ifdef FETCH_BOOT_VECTOR_EN
    m_boot = 1'b1; m_pc = 16'h0000;
`else
    m_boot = 1'b0; m_pc = RV;
`endif
    ldm_waiting = 1'b0; ldm_word = '0; ldm_addr = '0;
    m_out.inst = NOP; m_out.imm = '0; m_out.pc = '0; m_out.valid = 1'b0;
    m_out.addr = m_pc;
  endtask

  task automatic model_bubble();
    m_out.inst = NOP; m_out.imm = '0; m_out.valid = 1'b0;
  endtask

  // What one clock edge does, in instruction-level terms.
  task automatic model_edge(input bit st, input bit rd, input logic [15:0] rpc, input bit en);
    logic [15:0] w;
    if (rd) begin
      m_pc = rpc; m_boot = 1'b0; ldm_waiting = 1'b0; model_bubble();
    end else if (st) begin
    end else if (!en) begin
      model_bubble();
    end else if (m_boot) begin
      m_pc = mem[16'h0000]; m_boot = 1'b0; model_bubble();
    end else begin
      w = mem[m_pc];
      if (ldm_waiting) begin
        m_out.inst = ldm_word; m_out.imm = w; m_out.pc = ldm_addr; m_out.valid = 1'b1;
        ldm_waiting = 1'b0;
      end else if (w[15:11] == 5'b10001) begin
        ldm_word = w; ldm_addr = m_pc; ldm_waiting = 1'b1; model_bubble();
      end else begin
        m_out.inst = w; m_out.imm = '0; m_out.pc = m_pc; m_out.valid = 1'b1;
      end
      m_pc = m_pc + 16'd1;
    end
    m_out.addr = m_pc;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit st, input bit rd, input logic [15:0] rpc, input bit en);
    stall = st; redirect = rd; redirect_pc = rpc; pc_enable = en;
    model_edge(st, rd, rpc, en);
    exp_q.push_back(m_out);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; pc_enable = 1'b1;
    #1;
    model_reset();
    exp_q.delete();
    check("reset", sample(), m_out);
    @(negedge clk);
    @(negedge clk);
    check("reset_hold", sample(), m_out);
    rst_n = 1'b1;
  endtask

  // Monitor: one expected record per clock edge while out of reset.
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) check("ifid", sample(), exp_q.pop_front());
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0100 + 16'(i[7:0]);
    mem[0] = 16'h1000; mem[1] = 16'h2000; mem[2] = 16'h3000; mem[3] = 16'h0123;
    mem[4] = 16'h8800; mem[5] = 16'hBEEF;
    mem[16'h20] = 16'h8801; mem[16'h21] = 16'h8805;
    mem[16'h40] = 16'h1040; mem[16'h41] = 16'h1041;

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // Halt while an LDM waits for its immediate (an LDM-looking immediate).
    step(0, 1, 16'h0020, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // Redirect together with stall discards the pending LDM.
    step(0, 1, 16'h0020, 1);
    step(0, 0, 0, 1);
    step(1, 1, 16'h0040, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1);

    // PC wrap, plain and for an LDM at the top of memory.
    mem[16'hFFFF] = 16'h1234;
    step(0, 1, 16'hFFFF, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    mem[16'hFFFF] = 16'h8800; mem[0] = 16'hCAFE;
    step(0, 1, 16'hFFFF, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // Random memory image with plenty of LDMs, random control.
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(0, 3) == 0) mem[i][15:11] = 5'b10001;
    end
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                        : 16'($urandom);
      step($urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0, tgt,
           $urandom_range(0, 9) != 0);
    end

    // Asynchronous reset mid-stream, then more random traffic.
    do_reset();
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0, 16'($urandom),
           $urandom_range(0, 9) != 0);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected records never compared, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
